// File: rtl/nf_mc_pkg.sv
// rtl/nf_mc_pkg.sv - shared state encoding and defaults for the nanoFOX multi-cycle sequencer
package nf_mc_pkg;

  localparam int TO_CYC_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_ERR  = 3'd6
  } mc_state_e;

endpackage

// File: rtl/nf_mc_wdt.sv
// rtl/nf_mc_wdt.sv - bus watchdog; expired flags the last unacknowledged request cycle
module nf_mc_wdt
  import nf_mc_pkg::*;
#(
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam int W = $clog2(TO_CYC) + 1;
  localparam logic [W-1:0] LAST = W'(TO_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (req && !ack && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = req && !ack && (cnt_q == LAST);

endmodule

// File: rtl/nf_mc_seq.sv
// rtl/nf_mc_seq.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer sharing one bus
module nf_mc_seq
  import nf_mc_pkg::*;
#(
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        req,
  output logic        addr_sel,
  output logic        we,
  input  logic        ack,
  output logic        ir_we,
  output logic        pc_we,
  input  logic        we_rf_d,
  input  logic        we_dm_d,
  input  logic        rf_src_d,
  output logic        rf_we,
  output logic        busy,
  output logic [2:0]  state,
  output logic        err,
  output logic [31:0] instret
);

  mc_state_e   state_q, state_d;
  logic [31:0] instret_q;
  logic        wdt_clr;
  logic        wdt_expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Written only in WB so the count holds its value in every other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (state_q == ST_WB) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_IF;
      ST_IF: begin
        if (ack)              state_d = ST_ID;
        else if (wdt_expired) state_d = ST_ERR;
      end
      ST_ID:   state_d = ST_EX;
      ST_EX:   state_d = (we_dm_d || rf_src_d) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (ack)              state_d = ST_WB;
        else if (wdt_expired) state_d = ST_ERR;
      end
      ST_WB:   state_d = run ? ST_IF : ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wdt_clr = (state_d != state_q) && ((state_d == ST_IF) || (state_d == ST_MEM));

  nf_mc_wdt #(
    .TO_CYC (TO_CYC)
  ) u_wdt (
    .clk     (clk),
    .reset   (reset),
    .clr     (wdt_clr),
    .req     (req),
    .ack     (ack),
    .expired (wdt_expired)
  );

  assign req      = (state_q == ST_IF) || (state_q == ST_MEM);
  assign addr_sel = (state_q == ST_MEM);
  assign we       = (state_q == ST_MEM) && we_dm_d;
  assign ir_we    = (state_q == ST_IF) && ack;
  assign pc_we    = (state_q == ST_WB);
  assign rf_we    = (state_q == ST_WB) && we_rf_d;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign err      = (state_q == ST_ERR);
  assign state    = state_q;
  assign instret  = instret_q;

endmodule
